// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter that loads one requester's 4-bit slice into a shared register.
// Grant one edge after request, Reg_Out/Ack one edge later; owner holds until release or TIMEOUT.
module reg_load_arbiter #(
   parameter int TIMEOUT = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [3:0]  Req,
   input  logic [15:0] Data_In,
   output logic [3:0]  Grant,
   output logic        Ack,
   output logic [1:0]  Owner,
   output logic        Busy,
   output logic        Timeout,
   output logic [3:0]  Reg_Out
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [3:0]  grant_q, grant_d;
   logic [1:0]  owner_q, owner_d;
   logic        busy_q, busy_d;
   logic        ack_q, ack_d;
   logic        timeout_q, timeout_d;
   logic [3:0]  reg_out_q, reg_out_d;
   logic [3:0]  data_q, data_d;
   logic [1:0]  prio_q, prio_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [1:0]  pick_idx;
   logic [3:0]  pick_dat;

   // Walk downward in offset so the closest set bit at or above prio wins last.
   always_comb begin
      pick_idx = prio_q;
      for (int i = 3; i >= 0; i--) begin
         if (Req[prio_q + 2'(i)]) begin
            pick_idx = prio_q + 2'(i);
         end
      end
      pick_dat = Data_In[{pick_idx, 2'b00} +: 4];
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      ack_d     = 1'b0;
      timeout_d = 1'b0;
      reg_out_d = reg_out_q;
      data_d    = data_q;
      prio_d    = prio_q;
      cnt_d     = cnt_q;

      case (state_q)
         IDLE: begin
            if (|Req) begin
               state_d = LOAD;
               grant_d = 4'(4'b0001 << pick_idx);
               owner_d = pick_idx;
               busy_d  = 1'b1;
               data_d  = pick_dat;
            end else begin
               grant_d = 4'b0000;
               owner_d = 2'd0;
               busy_d  = 1'b0;
            end
         end
         LOAD: begin
            reg_out_d = data_q;
            ack_d     = 1'b1;
            cnt_d     = 4'd0;
            state_d   = WAIT_REL;
         end
         WAIT_REL: begin
            // A voluntary release on the same edge as the limit suppresses Timeout.
            if (!Req[owner_q] || cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               grant_d   = 4'b0000;
               owner_d   = 2'd0;
               busy_d    = 1'b0;
               prio_d    = owner_q + 2'd1;
               timeout_d = Req[owner_q];
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         grant_q   <= 4'b0000;
         owner_q   <= 2'd0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         timeout_q <= 1'b0;
         reg_out_q <= 4'd0;
         data_q    <= 4'd0;
         prio_q    <= 2'd0;
         cnt_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         timeout_q <= timeout_d;
         reg_out_q <= reg_out_d;
         data_q    <= data_d;
         prio_q    <= prio_d;
         cnt_q     <= cnt_d;
      end
   end

   assign Grant   = grant_q;
   assign Owner   = owner_q;
   assign Busy    = busy_q;
   assign Ack     = ack_q;
   assign Timeout = timeout_q;
   assign Reg_Out = reg_out_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Randomized and directed bench for reg_load_arbiter against a transaction-level model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_reg_load_arbiter;

   localparam int TO = 8;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [3:0]  Req;
   logic [15:0] Data_In;
   logic [3:0]  Grant;
   logic        Ack;
   logic [1:0]  Owner;
   logic        Busy;
   logic        Timeout;
   logic [3:0]  Reg_Out;

   int n_checks = 0;
   int n_fail   = 0;

   // model: rotating priority pointer and shared register contents
   logic [1:0] m_prio;
   logic [3:0] m_reg;

   reg_load_arbiter #(.TIMEOUT(TO)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Req     (Req),
      .Data_In (Data_In),
      .Grant   (Grant),
      .Ack     (Ack),
      .Owner   (Owner),
      .Busy    (Busy),
      .Timeout (Timeout),
      .Reg_Out (Reg_Out)
   );

   always #5 Clock = ~Clock;

   function automatic logic [1:0] arb(input logic [1:0] p, input logic [3:0] r);
      int k;
      for (int i = 0; i < 4; i++) begin
         k = (int'(p) + i) % 4;
         if (r[k]) return 2'(k);
      end
      return 2'd0;
   endfunction

   // One complete grant/load/release transaction; starts and ends at a falling
   // edge with the DUT idle. hold = WAIT_REL edges the owner keeps requesting.
   task automatic txn(input logic [3:0] pat, input logic [15:0] d, input logic [15:0] d2,
                      input int hold_in, input bit drop_in_load);
      logic [1:0]  own;
      logic [3:0]  slice;
      logic [3:0]  gnt;
      logic [12:0] exp, got;
      int          hold, exit_j;
      bit          exp_to;
      hold   = drop_in_load ? 0 : hold_in;
      own    = arb(m_prio, pat);
      slice  = d[own*4 +: 4];
      gnt    = 4'(4'b0001 << own);
      exit_j = (hold < TO - 1) ? hold : TO - 1;
      exp_to = (hold >= TO);

      Req = pat; Data_In = d;
      @(negedge Clock);
      exp = {gnt, own, 1'b1, 1'b0, 1'b0, m_reg};
      got = {Grant, Owner, Busy, Ack, Timeout, Reg_Out};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL grant: got %b want %b (pat %b)", got, exp, pat);
      end

      Data_In = d2;
      if (drop_in_load) Req[own] = 1'b0;
      @(negedge Clock);
      exp = {gnt, own, 1'b1, 1'b1, 1'b0, slice};
      got = {Grant, Owner, Busy, Ack, Timeout, Reg_Out};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL load_ack: got %b want %b", got, exp);
      end
      m_reg = slice;

      for (int j = 0; j <= exit_j; j++) begin
         Req[own] = (j < hold);
         Data_In  = 16'($urandom);
         @(negedge Clock);
         if (j < exit_j) exp = {gnt, own, 1'b1, 1'b0, 1'b0, m_reg};
         else            exp = {4'b0000, 2'd0, 1'b0, 1'b0, exp_to, m_reg};
         got = {Grant, Owner, Busy, Ack, Timeout, Reg_Out};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL wait_rel[%0d]: got %b want %b (hold %0d)", j, got, exp, hold);
         end
      end
      m_prio = own + 2'd1;
   endtask

   task automatic idle_cycle();
      logic [12:0] exp, got;
      Req = 4'b0000; Data_In = 16'($urandom);
      @(negedge Clock);
      exp = {4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, m_reg};
      got = {Grant, Owner, Busy, Ack, Timeout, Reg_Out};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL idle: got %b want %b", got, exp);
      end
   endtask

   task automatic test_reset();
      logic [12:0] got;
      Reset = 1'b1; Req = 4'($urandom_range(1, 15)); Data_In = 16'($urandom);
      repeat (3) @(negedge Clock);
      got = {Grant, Owner, Busy, Ack, Timeout, Reg_Out};
      n_checks++;
      if (got !== 13'd0) begin
         n_fail++;
         $display("FAIL reset: got %b want %b", got, 13'd0);
      end
      Reset = 1'b0; Req = 4'b0000;
      m_prio = 2'd0; m_reg = 4'd0;
      idle_cycle();
   endtask

   task automatic test_single();
      txn(4'b0100, 16'h3A5C, 16'h0000, 1, 1'b0);
      // pointer now 3: with 1011 requesting, requester 3 must win
      Req = 4'b1011; Data_In = 16'hB123;
      @(negedge Clock);
      n_checks++;
      if (Grant !== 4'b1000) begin
         n_fail++;
         $display("FAIL prio_after_single: got %b want %b", Grant, 4'b1000);
      end
      Req = 4'b0000;
      @(negedge Clock);
      n_checks++;
      if ({Ack, Reg_Out} !== {1'b1, 4'hB}) begin
         n_fail++;
         $display("FAIL single_load3: got %b want %b", {Ack, Reg_Out}, {1'b1, 4'hB});
      end
      @(negedge Clock);
      n_checks++;
      if ({Busy, Grant} !== 5'b0) begin
         n_fail++;
         $display("FAIL single_rel3: got %b want %b", {Busy, Grant}, 5'b0);
      end
      m_reg = 4'hB; m_prio = 2'd0;
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 5; i++) txn(4'b1111, 16'($urandom), 16'($urandom), 1, 1'b0);
   endtask

   task automatic test_timeout();
      txn(4'b0001, 16'h0009, 16'h0006, 100, 1'b0);
      idle_cycle();
   endtask

   task automatic test_data_stability();
      txn(4'b0001, 16'hFFF3, 16'h000C, 1, 1'b0);
   endtask

   task automatic test_release_vs_timeout();
      txn(4'b0010, 16'($urandom), 16'($urandom), TO - 1, 1'b0);
      idle_cycle();
   endtask

   task automatic test_drop_in_load();
      txn(4'b1000, 16'($urandom), 16'($urandom), 0, 1'b1);
   endtask

   task automatic test_mid_reset();
      txn(4'b0001, 16'h0006, 16'h0000, 1, 1'b0);
      Req = 4'b0100; Data_In = 16'h0F00;
      @(negedge Clock);
      n_checks++;
      if ({Grant, Busy} !== {4'b0100, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_reset_grant: got %b want %b", {Grant, Busy}, {4'b0100, 1'b1});
      end
      Reset = 1'b1; Req = 4'b1001; Data_In = 16'h7005;
      @(negedge Clock);
      n_checks++;
      if ({Grant, Owner, Busy, Ack, Timeout, Reg_Out} !== 13'd0) begin
         n_fail++;
         $display("FAIL mid_reset_abort: got %b want %b",
                  {Grant, Owner, Busy, Ack, Timeout, Reg_Out}, 13'd0);
      end
      Reset = 1'b0;
      @(negedge Clock);
      n_checks++;
      if ({Grant, Ack, Reg_Out} !== {4'b0001, 1'b0, 4'h0}) begin
         n_fail++;
         $display("FAIL post_reset_arb: got %b want %b", {Grant, Ack, Reg_Out}, {4'b0001, 1'b0, 4'h0});
      end
      Req = 4'b0000;
      @(negedge Clock);
      n_checks++;
      if ({Ack, Reg_Out} !== {1'b1, 4'h5}) begin
         n_fail++;
         $display("FAIL post_reset_load: got %b want %b", {Ack, Reg_Out}, {1'b1, 4'h5});
      end
      @(negedge Clock);
      n_checks++;
      if ({Busy, Timeout} !== 2'b00) begin
         n_fail++;
         $display("FAIL post_reset_rel: got %b want %b", {Busy, Timeout}, 2'b00);
      end
      m_reg = 4'h5; m_prio = 2'd1;
   endtask

   task automatic test_random();
      int  hold;
      bit  dil;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 2)) idle_cycle();
         hold = $urandom_range(0, TO + 2);
         dil  = (hold == 0) && ($urandom_range(0, 1) == 1);
         txn(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), hold, dil);
      end
   endtask

   initial begin
      Reset = 1'b1; Req = 4'b0000; Data_In = 16'h0000;
      m_prio = 2'd0; m_reg = 4'd0;
      @(negedge Clock);
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_data_stability();
      test_release_vs_timeout();
      test_drop_in_load();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
